// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared types and arithmetic helpers for the stochastic-to-binary converter
//
// Purpose: FSM state encoding, window-length helper and the unsigned/signed
// saturation helpers used by every channel's result path.
// Ports: none (package).

package sc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } sc_state_e;

  // Number of input bits per window.
  function automatic int unsigned sc_window(input int unsigned len);
    return 32'd1 << len;
  endfunction

  // Clamp an unsigned value to the largest w-bit unsigned number.
  function automatic logic [63:0] sc_sat_u(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    return (v > max_v) ? max_v : v;
  endfunction

  // Clamp a signed value to the w-bit two's complement range.
  function automatic logic signed [63:0] sc_sat_s(input logic signed [63:0] v, input int unsigned w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 1));
    if (v > max_v) begin
      return max_v;
    end else if (v < min_v) begin
      return min_v;
    end
    return v;
  endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// rtl/sc_ones_counter.sv - per-channel ones counter with scale/shift/saturate result path
//
// Purpose: counts ones of one stochastic channel over a window and produces the
// scaled binary result from the count including the current bit, so the top
// can register it on the final bit cycle.
// Build option: SC_TO_BINARY_BIPOLAR_EN selects bipolar (signed) encoding;
// undefined gives unipolar (unsigned).
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - clear the count (final bit of the window)
//   inc       - bit accepted this cycle
//   bit_in    - stochastic bit of this channel
//   scale     - full-scale value
//   res       - result computed from count + bit_in (combinational)

module sc_ones_counter
  import sc_pkg::*;
#(
  parameter int LEN     = 4,
  parameter int SCALE_W = 8,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  input  logic               bit_in,
  input  logic [SCALE_W-1:0] scale,
  output logic [OUT_W-1:0]   res
);

  logic [LEN:0] ones_q;
  logic [LEN:0] ones_d;
  logic [LEN:0] tot;

  // tot is the count as it stands after this cycle's bit; on the final bit it
  // can reach 2**LEN, which is why the counter is one bit wider than LEN.
  always_comb begin
    tot    = ones_q + (LEN + 1)'(bit_in);
    ones_d = ones_q;
    if (clr) begin
      ones_d = '0;
    end else if (inc) begin
      ones_d = tot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

`ifdef SC_TO_BINARY_BIPOLAR_EN
  logic signed [63:0] tot_s;
  logic signed [63:0] scale_s;
  logic signed [63:0] prod_s;

  // (2*ones - 2**LEN) maps the count onto -2**LEN..+2**LEN; the arithmetic
  // shift then rounds toward minus infinity.
  always_comb begin
    tot_s   = signed'(64'(tot));
    scale_s = signed'(64'(scale));
    prod_s  = ((tot_s <<< 1) - (64'sd1 <<< LEN)) * scale_s;
    res     = OUT_W'(sc_sat_s(prod_s >>> LEN, OUT_W));
  end
`else
  logic [63:0] prod_u;

  always_comb begin
    prod_u = 64'(tot) * 64'(scale);
    res    = OUT_W'(sc_sat_u(prod_u >> LEN, OUT_W));
  end
`endif

endmodule

// File: rtl/sc_to_binary_nch.sv
// rtl/sc_to_binary_nch.sv - multi-channel stochastic-to-binary converter top
//
// Purpose: accepts one bit per channel per handshake, counts ones over a
// window of 2**LEN accepted bits, then presents scaled results and holds them
// until the consumer accepts.
// Build option: SC_TO_BINARY_BIPOLAR_EN selects bipolar two's complement results.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   scale                - full-scale value, sampled on the final bit cycle
//   in_valid/in_ready    - input handshake, in_bits[c] is channel c
//   out_valid/out_ready  - output handshake
//   out_data             - channel c result at [c*OUT_W +: OUT_W]
//   win_cnt              - bits accepted so far in the current window

module sc_to_binary_nch
  import sc_pkg::*;
#(
  parameter int LEN     = 4,
  parameter int N_CH    = 1,
  parameter int SCALE_W = 8,
  parameter int OUT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SCALE_W-1:0]    scale,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_CH-1:0]       in_bits,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_CH*OUT_W-1:0] out_data,
  output logic [LEN-1:0]        win_cnt
);

  localparam logic [LEN-1:0] WIN_LAST = LEN'(sc_window(LEN) - 1);
  localparam logic [LEN-1:0] CNT_ONE  = LEN'(1);

  sc_state_e             state_q, state_d;
  logic [LEN-1:0]        win_cnt_q, win_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [N_CH*OUT_W-1:0] out_data_q, out_data_d;
  logic [N_CH*OUT_W-1:0] ch_res;
  logic                  accept;
  logic                  last_bit;

  assign in_ready  = (state_q == ACCUM);
  assign accept    = in_valid && in_ready;
  assign last_bit  = accept && (win_cnt_q == WIN_LAST);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign win_cnt   = win_cnt_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    sc_ones_counter #(
      .LEN     (LEN),
      .SCALE_W (SCALE_W),
      .OUT_W   (OUT_W)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (last_bit),
      .inc    (accept),
      .bit_in (in_bits[c]),
      .scale  (scale),
      .res    (ch_res[c*OUT_W +: OUT_W])
    );
  end

  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          // Wraps to zero naturally on the final bit.
          win_cnt_d = win_cnt_q + CNT_ONE;
        end
        if (last_bit) begin
          out_data_d  = ch_res;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      win_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_sc_to_binary_nch.sv
// tb/tb_sc_to_binary_nch.sv - self-checking bench for sc_to_binary_nch (LEN=4, N_CH=2)

module tb_sc_to_binary_nch;

  localparam int LEN     = 4;
  localparam int N_CH    = 2;
  localparam int SCALE_W = 8;
  localparam int OUT_W   = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [SCALE_W-1:0]    scale = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [N_CH-1:0]       in_bits = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [N_CH*OUT_W-1:0] out_data;
  logic [LEN-1:0]        win_cnt;

  int total = 0;
  int bad   = 0;

  logic [N_CH*OUT_W-1:0] exp_q[$];

  typedef struct {
    logic [15:0] p0;
    logic [15:0] p1;
    logic [7:0]  sc;
    bit          gaps;
    bit          bp;
    logic [7:0]  e0;
    logic [7:0]  e1;
  } vec_t;

  vec_t vecs[6];

  sc_to_binary_nch #(
    .LEN     (LEN),
    .N_CH    (N_CH),
    .SCALE_W (SCALE_W),
    .OUT_W   (OUT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scale     (scale),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .win_cnt   (win_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bipolar builds derive expectations from a reference formula; unipolar
  // builds use the hand-computed table values.
  function automatic logic [7:0] expect_ch(input logic [15:0] p, input logic [7:0] sc,
                                           input logic [7:0] e_uni);
`ifdef SC_TO_BINARY_BIPOLAR_EN
    int v;
    v = ((2 * $countones(p) - 16) * int'(sc)) >>> 4;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[7:0];
`else
    if (^{p, sc} === 1'bx) return 8'hxx;
    return e_uni;
`endif
  endfunction

  // Scoreboard: results are consumed on the edge following a negedge that
  // sees out_valid && out_ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got %0h want none", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic run_window(input vec_t v);
    logic [N_CH*OUT_W-1:0] held;
    out_ready = !v.bp;
    for (int k = 0; k < 16; k++) begin
      if (v.gaps) begin
        in_valid = 1'b0;
        in_bits  = 2'($urandom);
        scale    = 8'($urandom);
        @(posedge clk); #1;
        check("gap_win_cnt", win_cnt, k);
      end
      in_valid = 1'b1;
      in_bits  = {v.p1[k], v.p0[k]};
      if (k == 15) begin
        scale = v.sc;
        exp_q.push_back({expect_ch(v.p1, v.sc, v.e1), expect_ch(v.p0, v.sc, v.e0)});
      end else begin
        scale = 8'($urandom);
      end
      @(posedge clk); #1;
      if (k < 15) check("win_cnt", win_cnt, k + 1);
    end
    in_valid = 1'b0;
    check("lat_out_valid", out_valid, 1);
    check("wrap_win_cnt", win_cnt, 0);
    check("hold_in_ready", in_ready, 0);
    if (v.bp) begin
      held     = out_data;
      in_valid = 1'b1;
      in_bits  = 2'b11;
      repeat (10) begin
        @(posedge clk); #1;
        check("bp_data", out_data, held);
        check("bp_in_ready", in_ready, 0);
        check("bp_win_cnt", win_cnt, 0);
        check("bp_valid", out_valid, 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("ack_out_valid", out_valid, 0);
    check("ack_in_ready", in_ready, 1);
    check("ack_win_cnt", win_cnt, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //          p0        p1        sc     gaps  bp    e0      e1
    vecs[0] = '{16'hFFFF, 16'h0000, 8'd200, 1'b0, 1'b1, 8'd200, 8'd0};
    vecs[1] = '{16'h00FF, 16'h001F, 8'd200, 1'b0, 1'b0, 8'd100, 8'd62};
    vecs[2] = '{16'hFFF0, 16'h0001, 8'd255, 1'b1, 1'b0, 8'd191, 8'd15};
    vecs[3] = '{16'hAAAA, 16'hFFFF, 8'd255, 1'b0, 1'b0, 8'd127, 8'd255};
    vecs[4] = '{16'h0000, 16'h0000, 8'd77,  1'b0, 1'b1, 8'd0,   8'd0};
    vecs[5] = '{16'h7FFF, 16'h0003, 8'd16,  1'b1, 1'b0, 8'd15,  8'd2};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_win_cnt", win_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 6; i++) begin
      run_window(vecs[i]);
    end

    // Asynchronous reset mid-window at win_cnt=9
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bits   = 2'b11;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("mid_win_cnt", win_cnt, 9);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_win_cnt", win_cnt, 0);
    check("mid_rst_out_valid", out_valid, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready, 1);
    v = '{16'h000F, 16'h0F0F, 8'd100, 1'b0, 1'b0, 8'd25, 8'd50};
    run_window(v);

    // Asynchronous reset during HOLD
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bits   = 2'b11;
    scale     = 8'd200;
    repeat (16) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("hold_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("hold_rst_out_valid", out_valid, 0);
    check("hold_rst_out_data", out_data, 0);
    check("hold_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    v = '{16'h0F00, 16'h8001, 8'd64, 1'b0, 1'b0, 8'd16, 8'd8};
    run_window(v);

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
